// File: rtl/noise_gate_pkg.sv
// Shared types, constants and helpers for the noise gate dynamics stage.
package noise_gate_pkg;

  typedef enum logic [2:0] {
    CLOSED,
    ATTACK,
    OPEN,
    HOLD,
    RELEASE
  } gate_state_t;

  typedef logic signed [15:0] sample_t;

  // Q1.15 unity; needs the 16th bit, so gain is carried as unsigned 16-bit.
  localparam logic [15:0] GAIN_UNITY = 16'd32768;

  // |s| clipped to 15 bits; -32768 folds onto 32767 so the envelope never wraps.
  function automatic logic [14:0] sat_mag(input sample_t s);
    logic [15:0] m;
    m = s[15] ? (16'(~s) + 16'd1) : 16'(s);
    return m[15] ? 15'h7fff : m[14:0];
  endfunction

endpackage

// File: rtl/noise_gate_envelope_follower.sv
// Peak envelope follower: instant attack to the rectified sample, exponential
// decay of env >> DECAY_SHIFT per sample otherwise.
module envelope_follower
  import noise_gate_pkg::*;
#(
  parameter int DECAY_SHIFT = 8
) (
  input  logic        clk_48,
  input  logic        reset,
  input  logic [15:0] sampleIn,
  output logic [14:0] env
);

  logic [14:0] mag;
  logic [14:0] decay;

  // Rectify the incoming sample and form this clock's decay amount.
  always_comb begin
    mag   = sat_mag(sample_t'(sampleIn));
    decay = env >> DECAY_SHIFT;
  end

  // Peak capture, else decay; below 2^DECAY_SHIFT the decay rounds to zero and env parks.
  always_ff @(posedge clk_48 or posedge reset) begin
    if (reset) begin
      env <= '0;
    end else if (mag > env) begin
      env <= mag;
    end else begin
      env <= env - decay;
    end
  end

endmodule

// File: rtl/noise_gate.sv
// Noise gate: envelope-driven five-state gate with click-free Q1.15 gain ramps.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   CLOSED  | gain 0, waiting for env >= threshold
//   ATTACK  | gain ramping up by ATTACK_STEP, ignores env until unity
//   OPEN    | gain unity, waiting for env < threshold >> 1
//   HOLD    | gain unity, counting down HOLD_SAMPLES unless retriggered
//   RELEASE | gain ramping down by RELEASE_STEP, retriggers into ATTACK
module noise_gate
  import noise_gate_pkg::*;
#(
  parameter int ATTACK_STEP  = 1024,
  parameter int RELEASE_STEP = 64,
  parameter int HOLD_SAMPLES = 2400,
  parameter int DECAY_SHIFT  = 8
) (
  input  logic        clk_48,
  input  logic        reset,
  input  logic        enable,
  input  logic [14:0] threshold,
  input  logic [15:0] gateIn,
  output logic [15:0] gateOut,
  output logic        gateOpen,
  output logic [14:0] envelope
);

  localparam int HOLD_W = (HOLD_SAMPLES > 2) ? $clog2(HOLD_SAMPLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD   = HOLD_W'(HOLD_SAMPLES - 1);
  localparam logic [16:0]       ATTACK_INC  = 17'(ATTACK_STEP);
  localparam logic [15:0]       RELEASE_DEC = 16'(RELEASE_STEP);

  gate_state_t        state;
  gate_state_t        state_nxt;
  logic [15:0]        gain;
  logic [15:0]        gain_nxt;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [HOLD_W-1:0]  hold_cnt_nxt;

  logic [14:0]        thr_close;
  logic               env_ge_open;
  logic               env_lt_close;
  logic [16:0]        gain_up;
  logic [15:0]        gain_sat_up;
  logic [15:0]        gain_sat_dn;

  logic signed [15:0] in_s;
  logic signed [16:0] gain_s;
  logic signed [32:0] product;
  logic [15:0]        gated;
  logic               unused_product;

  envelope_follower #(
    .DECAY_SHIFT(DECAY_SHIFT)
  ) u_env (
    .clk_48  (clk_48),
    .reset   (reset),
    .sampleIn(gateIn),
    .env     (envelope)
  );

  // Threshold compares against the registered envelope and saturated ramp steps.
  always_comb begin
    thr_close    = threshold >> 1;
    env_ge_open  = (envelope >= threshold);
    env_lt_close = (envelope < thr_close);
    gain_up      = {1'b0, gain} + ATTACK_INC;
    gain_sat_up  = (gain_up >= {1'b0, GAIN_UNITY}) ? GAIN_UNITY : gain_up[15:0];
    gain_sat_dn  = (gain > RELEASE_DEC) ? (gain - RELEASE_DEC) : '0;
  end

  // Gain multiply on the pre-update gain; bits [30:15] are the arithmetic >>> 15.
  always_comb begin
    in_s    = gateIn;
    gain_s  = {1'b0, gain};
    product = 33'(in_s) * 33'(gain_s);
    gated   = product[30:15];
  end

  assign unused_product = ^{product[32:31], product[14:0]};

  // Next-state, gain ramp and hold countdown; bypass pins the gate fully open.
  always_comb begin
    state_nxt    = state;
    gain_nxt     = gain;
    hold_cnt_nxt = hold_cnt;
    if (!enable) begin
      state_nxt    = OPEN;
      gain_nxt     = GAIN_UNITY;
      hold_cnt_nxt = '0;
    end else begin
      case (state)
        CLOSED: begin
          gain_nxt = '0;
          if (env_ge_open) begin
            state_nxt = ATTACK;
          end
        end
        ATTACK: begin
          gain_nxt = gain_sat_up;
          if (gain_sat_up == GAIN_UNITY) begin
            state_nxt = OPEN;
          end
        end
        OPEN: begin
          gain_nxt = GAIN_UNITY;
          if (env_lt_close) begin
            state_nxt    = HOLD;
            hold_cnt_nxt = HOLD_LOAD;
          end
        end
        HOLD: begin
          gain_nxt = GAIN_UNITY;
          if (env_ge_open) begin
            state_nxt = OPEN;
          end else if (hold_cnt == '0) begin
            state_nxt = RELEASE;
          end else begin
            hold_cnt_nxt = hold_cnt - HOLD_W'(1);
          end
        end
        RELEASE: begin
          if (env_ge_open) begin
            state_nxt = ATTACK;
          end else begin
            gain_nxt = gain_sat_dn;
            if (gain_sat_dn == '0) begin
              state_nxt = CLOSED;
            end
          end
        end
        default: begin
          state_nxt    = CLOSED;
          gain_nxt     = '0;
          hold_cnt_nxt = '0;
        end
      endcase
    end
  end

  // State, gain, counter and output registers; gateOpen follows the next state.
  always_ff @(posedge clk_48 or posedge reset) begin
    if (reset) begin
      state    <= CLOSED;
      gain     <= '0;
      hold_cnt <= '0;
      gateOut  <= '0;
      gateOpen <= 1'b0;
    end else begin
      state    <= state_nxt;
      gain     <= gain_nxt;
      hold_cnt <= hold_cnt_nxt;
      gateOut  <= enable ? gated : gateIn;
      gateOpen <= (state_nxt == OPEN) || (state_nxt == HOLD);
    end
  end

endmodule

// File: tb/tb_noise_gate.sv
// Self-checking bench for noise_gate: table vectors, directed ramp/hold
// sequences and randomized stimulus against a per-sample reference model.
module tb_noise_gate;

  logic               clk_48 = 1'b0;
  logic               reset;
  logic               enable;
  logic [14:0]        threshold;
  logic signed [15:0] gate_in;
  logic signed [15:0] gate_out;
  logic               gate_open;
  logic [14:0]        envelope;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  localparam int S_CLOSED  = 0;
  localparam int S_ATTACK  = 1;
  localparam int S_OPEN    = 2;
  localparam int S_HOLD    = 3;
  localparam int S_RELEASE = 4;
  int m_state, m_gain, m_env, m_hold, m_out, m_open;

  typedef struct {
    bit en;
    int thr;
    int din;
    int exp_out;
    int exp_open;
    int exp_env;
  } vec_t;
  vec_t tbl[6];

  int n, j, cnt, r_run, r_mode, r_t, r_x;
  bit r_en;

  noise_gate dut (
    .clk_48   (clk_48),
    .reset    (reset),
    .enable   (enable),
    .threshold(threshold),
    .gateIn   (gate_in),
    .gateOut  (gate_out),
    .gateOpen (gate_open),
    .envelope (envelope)
  );

  always #5 clk_48 = ~clk_48;

  task automatic check(input string name, input int actual, input int expected);
    n_vec++;
    if (actual != expected) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic int floor_div(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // samples of silence after a peak until the decayed envelope drops below tc
  function automatic int edges_to_hold(input int peak, input int tc);
    int e, k;
    e = peak;
    k = 0;
    while (e >= tc && k < 100000) begin
      e = e - e / 256;
      k++;
    end
    return k;
  endfunction

  task automatic model_reset();
    m_state = S_CLOSED;
    m_gain  = 0;
    m_env   = 0;
    m_hold  = 0;
    m_out   = 0;
    m_open  = 0;
  endtask

  task automatic model_clock(input bit en, input int t, input int x);
    int mag, env_next, tc;
    mag = (x < 0) ? -x : x;
    if (mag > 32767) mag = 32767;
    env_next = (mag > m_env) ? mag : m_env - m_env / 256;
    tc = t / 2;
    m_out = en ? floor_div(x * m_gain, 32768) : x;
    if (!en) begin
      m_state = S_OPEN;
      m_gain  = 32768;
      m_hold  = 0;
    end else if (m_state == S_CLOSED) begin
      m_gain = 0;
      if (m_env >= t) m_state = S_ATTACK;
    end else if (m_state == S_ATTACK) begin
      m_gain = (m_gain + 1024 > 32768) ? 32768 : m_gain + 1024;
      if (m_gain == 32768) m_state = S_OPEN;
    end else if (m_state == S_OPEN) begin
      if (m_env < tc) begin
        m_state = S_HOLD;
        m_hold  = 2400 - 1;
      end
    end else if (m_state == S_HOLD) begin
      if (m_env >= t) m_state = S_OPEN;
      else if (m_hold == 0) m_state = S_RELEASE;
      else m_hold = m_hold - 1;
    end else begin
      if (m_env >= t) m_state = S_ATTACK;
      else begin
        m_gain = (m_gain - 64 < 0) ? 0 : m_gain - 64;
        if (m_gain == 0) m_state = S_CLOSED;
      end
    end
    m_open = (m_state == S_OPEN || m_state == S_HOLD) ? 1 : 0;
    m_env  = env_next;
  endtask

  // one sample: drive, clock, advance model, compare just after the edge
  task automatic step(input bit en, input int t, input int x);
    enable    = en;
    threshold = 15'(t);
    gate_in   = 16'(x);
    @(posedge clk_48);
    model_clock(en, t, x);
    #1;
    check("model_out", gate_out, m_out);
    check("model_open", gate_open, m_open);
    check("model_env", envelope, m_env);
  endtask

  // step with fixed inputs until gateOpen reaches level; n = steps taken, -1 on timeout
  task automatic wait_level(input bit level, input int t, input int x, input int budget,
                            output int steps);
    steps = -1;
    for (int i = 1; i <= budget; i++) begin
      step(1'b1, t, x);
      if (gate_open === level) begin
        steps = i;
        break;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #2;
    check("rst_out", gate_out, 0);
    check("rst_open", gate_open, 0);
    check("rst_env", envelope, 0);
    @(posedge clk_48);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    enable    = 1'b1;
    threshold = '0;
    gate_in   = '0;
    reset     = 1'b1;

    tbl[0] = '{1'b0, 32767, -32768, -32768, 1, 32767};
    tbl[1] = '{1'b0, 32767,    100,    100, 1, 32640};
    tbl[2] = '{1'b0, 32767,     -5,     -5, 1, 32513};
    tbl[3] = '{1'b1, 32767,      0,      0, 1, 32386};
    tbl[4] = '{1'b1, 32767,   1000,   1000, 1, 32260};
    tbl[5] = '{1'b1, 32767,     -1,     -1, 1, 32134};

    // attack from reset with a steady tone above threshold
    do_reset();
    step(1'b1, 1000, 5000);
    check("a_env_first", envelope, 5000);
    check("a_out_first", gate_out, 0);
    check("a_open_first", gate_open, 0);
    wait_level(1'b1, 1000, 5000, 100, n);
    check("a_open_edge", n + 1, 34);
    step(1'b1, 1000, 5000);
    check("a_out_unity", gate_out, 5000);

    // decay into HOLD, then retrigger: the countdown must restart from scratch
    j = edges_to_hold(5000, 500);
    repeat (j + 1 + 100) step(1'b1, 1000, 0);
    check("hold_open", gate_open, 1);
    step(1'b1, 1000, -6000);
    check("hold_retrig_out", gate_out, -6000);
    check("hold_retrig_env", envelope, 6000);
    wait_level(1'b0, 1000, 0, 6000, n);
    check("retrig_fall_edge", n, edges_to_hold(6000, 500) + 2401);

    // re-attack from mid-release at gain 16384
    repeat (255) step(1'b1, 1000, 0);
    step(1'b1, 1000, 3000);
    step(1'b1, 1000, 3000);
    step(1'b1, 1000, 3000);
    check("rel_attack_out", gate_out, 1500);
    check("rel_attack_open", gate_open, 0);
    wait_level(1'b1, 1000, 3000, 100, n);
    check("rel_attack_edges", n, 15);
    step(1'b1, 1000, 3000);
    check("rel_attack_unity", gate_out, 3000);

    // full hold + release down to silence, below-threshold tone shows the ramp
    wait_level(1'b0, 1000, 0, 6000, n);
    check("fall_edge", n, edges_to_hold(3000, 500) + 2401);
    for (int m = 1; m <= 513; m++) begin
      step(1'b1, 1000, 999);
      if (m == 1) check("rel_first_out", gate_out, 999);
      if (m == 512) check("rel_last_out", gate_out, 1);
      if (m == 513) check("rel_zero_out", gate_out, 0);
    end
    cnt = 0;
    repeat (20) begin
      step(1'b1, 1000, 999);
      if (gate_open !== 1'b0 || gate_out !== 16'sd0) cnt++;
    end
    check("closed_hysteresis", cnt, 0);

    // bypass and hysteresis table
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].en, tbl[i].thr, tbl[i].din);
      check($sformatf("tbl%0d_out", i), gate_out, tbl[i].exp_out);
      check($sformatf("tbl%0d_open", i), gate_open, tbl[i].exp_open);
      check($sformatf("tbl%0d_env", i), envelope, tbl[i].exp_env);
    end

    // asynchronous reset in the middle of an attack ramp
    do_reset();
    repeat (10) step(1'b1, 1000, 5000);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("midrst_out", gate_out, 0);
    check("midrst_open", gate_open, 0);
    check("midrst_env", envelope, 0);
    @(posedge clk_48);
    #1;
    reset = 1'b0;
    step(1'b1, 1000, 5000);
    check("midrst_first_out", gate_out, 0);
    wait_level(1'b1, 1000, 5000, 100, n);
    check("midrst_open_edge", n + 1, 34);

    // zero threshold: opens straight from reset and never closes
    do_reset();
    step(1'b1, 0, 0);
    check("t0_open_first", gate_open, 0);
    wait_level(1'b1, 0, 0, 100, n);
    check("t0_open_edge", n + 1, 33);
    cnt = 0;
    repeat (3000) begin
      step(1'b1, 0, int'($urandom_range(0, 200)));
      if (gate_open !== 1'b1) cnt++;
    end
    check("t0_stays_open", cnt, 0);

    // randomized runs against the model
    do_reset();
    r_run  = 0;
    r_mode = 0;
    r_t    = 1000;
    r_en   = 1'b1;
    for (int c = 0; c < 24000; c++) begin
      if (r_run == 0) begin
        r_run  = int'($urandom_range(8, 3500));
        r_mode = int'($urandom_range(0, 4));
        if ($urandom_range(0, 3) == 0) begin
          case ($urandom_range(0, 4))
            0:       r_t = 0;
            1:       r_t = 300;
            2:       r_t = 1000;
            3:       r_t = 8000;
            default: r_t = int'($urandom_range(0, 32767));
          endcase
          r_en = ($urandom_range(0, 7) != 0);
        end
        if ($urandom_range(0, 11) == 0) do_reset();
      end
      r_run--;
      case (r_mode)
        1:       r_x = int'($urandom_range(0, 800)) - 400;
        2:       r_x = int'($urandom_range(0, 65535)) - 32768;
        3:       r_x = ($urandom_range(0, 1) == 1) ? 32767 : -32768;
        default: r_x = 0;
      endcase
      step(r_en, r_t, r_x);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/noise_gate.md
Name: noise_gate

Overview:
- Sample-rate dynamics stage in the channel strip. Inserted between the mute stage and the output level meter.
- Runs on the 48 kHz sample clock and processes one signed 16-bit sample per clock.
- Tracks a peak envelope of the input and drives a five-state gate FSM.
- Ramps a Q1.15 gain between 0 and unity, so signal below threshold is attenuated to silence without clicks.

Parameters:
ATTACK_STEP, 1024, gain increment per sample while opening (Q1.15 units)
RELEASE_STEP, 64, gain decrement per sample while closing
HOLD_SAMPLES, 2400, samples the gate stays open after envelope falls below close threshold (50 ms)
DECAY_SHIFT, 8, envelope decay per sample = env >> DECAY_SHIFT

Ports:
clk_48  in  1  48 kHz sample clock, one sample per rising edge
reset  in  1  asynchronous, active-high reset
enable  in  1  1 = gate active, 0 = bypass
threshold  in  15  open threshold, unsigned magnitude; close threshold = threshold >> 1
gateIn  in  16  signed input sample
gateOut  out  16  signed gated output sample
gateOpen  out  1  1 while state is OPEN or HOLD
envelope  out  15  current envelope value (for metering)

Behaviour:
- Reset (asynchronous, active-high): state CLOSED, gain 0, env 0, hold counter 0, gateOut 0, gateOpen 0.
- Magnitude: abs(gateIn) saturated to 15 bits; -32768 maps to 32767.
- Envelope, registered each clock:
  - if abs > env then env <= abs
  - else env <= env - (env >> DECAY_SHIFT)
  - once env < 2^DECAY_SHIFT it holds; it does not reach 0 except via a new attack or reset.
- FSM compares the registered env (one cycle behind gateIn) with threshold (T) and T>>1 (Tc). States:
  - CLOSED: gain 0. env >= T -> ATTACK.
  - ATTACK: gain <= min(gain + ATTACK_STEP, 32768). When the new gain equals 32768 -> OPEN. Stays in ATTACK regardless of env.
  - OPEN: gain 32768. env < Tc -> HOLD, load counter with HOLD_SAMPLES-1.
  - HOLD: gain 32768.
    - env >= T -> OPEN (retrigger).
    - else if counter == 0 -> RELEASE.
    - else decrement counter.
  - RELEASE:
    - env >= T -> ATTACK, ramping up from the current gain.
    - else gain <= max(gain - RELEASE_STEP, 0); when the new gain is 0 -> CLOSED.
- Hysteresis: env between Tc and T in OPEN stays OPEN; in CLOSED stays CLOSED.
- T = 0: env >= T always, so after reset the gate goes CLOSED -> ATTACK -> OPEN and stays open.
- Gain arithmetic: 16-bit unsigned, range 0..32768.
  - gateOut <= (gateIn * gain) >>> 15; 32-bit signed product, arithmetic shift.
  - Latency 1 clock; uses the gain register value before this clock's update.
  - gain = 32768 gives gateOut == gateIn exactly; no saturation required.
- enable = 0:
  - gateOut <= gateIn (latency still 1).
  - State forced to OPEN, gain forced to 32768, hold counter cleared.
  - env keeps tracking.
  - gateOpen = 1.
- enable 0 -> 1: resume from OPEN.
- Reset asserted mid-ramp: immediate return to reset values. First sample after release is processed from CLOSED.
- gateOpen is registered, derived from the next-state value, so it aligns with the state register.

Decomposition:
- Package noise_gate_pkg:
  - typedef enum logic [2:0] gate_state_t {CLOSED, ATTACK, OPEN, HOLD, RELEASE}
  - localparam GAIN_UNITY = 16'd32768
  - sample_t (logic signed [15:0])
- One sub-module, envelope_follower (clk_48, reset, sampleIn, env): magnitude plus peak/decay register, parameterised by DECAY_SHIFT.
- FSM, hold counter, gain ramp and multiplier stay in noise_gate.

Test Plan:
- Reset then enable=1, T=1000, gateIn constant 5000:
  - envelope=5000 one cycle after the first sample;
  - ATTACK next cycle;
  - gain reaches 32768 after 32 cycles;
  - gateOpen=1;
  - gateOut=5000 thereafter.
- From OPEN, gateIn drops to 0 -> envelope decays per the shift rule:
  - HOLD entered on the first cycle env < 500 (cycle count checked against a reference model);
  - exactly 2400 cycles later RELEASE;
  - gain reaches 0 after 512 cycles; state CLOSED; gateOpen=0.
- During HOLD, apply gateIn=-6000 -> env=6000 -> back to OPEN, counter abandoned, gain stays 32768.
- During RELEASE at gain 16384, apply gateIn=3000 -> ATTACK from 16384; OPEN after 16 cycles.
- enable=0 with T=32767 and gateIn=-32768 -> gateOut=-32768 after 1 cycle, gateOpen=1; envelope=32767.
- Assert reset mid-ATTACK -> gateOut, gain, envelope and gateOpen are all 0 immediately, without waiting for a clock edge.
